rc5_encrypt: RTL and testbench

Iterative RC5-W/R encryption core: the consumer/reader side of the expanded key table S[0..T-1] produced by the key-schedule logic. It accepts one plaintext block (A,B) on a start strobe and fetches one subkey per iteration through a read-only address/data port to the shared S RAM. It computes the RC5 rounds one half-round at a time and presents the ciphertext with a done pulse. The core never writes S; the key-schedule block owns the RAM write port.

---
 rtl/rc5_encrypt.sv | 152 +++++++++++++++
 tb/tb_rc5_encrypt.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc5_encrypt.sv
// -----------------------------------------------------------------------------
// rc5_encrypt
//
// Iterative RC5-W/R block encryption core. Reads the expanded key table
// S[0..T-1] from a shared RAM through a read-only address/data port (one
// cycle read latency) and applies one half-round per subkey, two cycles per
// subkey (RAM wait + operate). The core never writes S.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   iStart       start strobe, sampled only while idle
//   iA, iB       plaintext words, captured on the accepting edge
//   oS_address   registered S RAM read address
//   iS_sub_i     S RAM read data, valid one cycle after oS_address changes
//   oA, oB       working registers; hold the ciphertext after oDone
//   oBusy        high while an encryption is in progress
//   oDone        one-cycle pulse when oA/oB hold the final ciphertext
// -----------------------------------------------------------------------------
module rc5_encrypt #(
  parameter  int W        = 32,
  parameter  int R        = 12,
  localparam int T        = 2 * R + 2,
  localparam int T_LENGTH = $clog2(T),
  localparam int LGW      = $clog2(W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iStart,
  input  logic [W-1:0]        iA,
  input  logic [W-1:0]        iB,
  output logic [T_LENGTH-1:0] oS_address,
  input  logic [W-1:0]        iS_sub_i,
  output logic [W-1:0]        oA,
  output logic [W-1:0]        oB,
  output logic                oBusy,
  output logic                oDone
);

  localparam logic [T_LENGTH-1:0] LAST_IDX = T_LENGTH'(T - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DATA,
    OPERATE_DATA,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [T_LENGTH-1:0]   idx_q, idx_d;
  logic [T_LENGTH-1:0]   addr_q, addr_d;
  logic [W-1:0]          a_q, a_d;
  logic [W-1:0]          b_q, b_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Left rotate built from a doubled word so an amount of 0 needs no special
  // case and no shift by the full word width is ever formed.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x,
                                        input logic [LGW-1:0] amt);
    logic [2*W-1:0] t;
    t = {x, x} << amt;
    return t[2*W-1:W];
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (iStart) begin
          a_d     = iA;
          b_d     = iB;
          addr_d  = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = WAIT_DATA;
        end
      end

      WAIT_DATA: begin
        state_d = OPERATE_DATA;
      end

      OPERATE_DATA: begin
        // Index 0/1 are the pre-whitening additions; afterwards even indices
        // update A and odd indices update B, the odd step seeing the A just
        // written by the preceding even step.
        if (idx_q == '0) begin
          a_d = a_q + iS_sub_i;
        end else if (idx_q == T_LENGTH'(1)) begin
          b_d = b_q + iS_sub_i;
        end else if (!idx_q[0]) begin
          a_d = rotl(a_q ^ b_q, b_q[LGW-1:0]) + iS_sub_i;
        end else begin
          b_d = rotl(b_q ^ a_q, a_q[LGW-1:0]) + iS_sub_i;
        end

        if (idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          addr_d  = idx_q + 1'b1;
          state_d = WAIT_DATA;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign oS_address = addr_q;
  assign oA         = a_q;
  assign oB         = b_q;
  assign oBusy      = busy_q;
  assign oDone      = done_q;

endmodule

// File: tb/tb_rc5_encrypt.sv
// -----------------------------------------------------------------------------
// tb_rc5_encrypt
//
// Self-checking bench for rc5_encrypt. Two instances: R=12 (main) and R=1
// (hand vector). Each S RAM is modelled as an array with a one-cycle
// registered read. Expected ciphertexts come from a plain-arithmetic RC5
// reference model; the standard vector uses an RC5 key schedule computed here.
// -----------------------------------------------------------------------------
module tb_rc5_encrypt;

  localparam int T12 = 26;

  logic        clk = 1'b0;
  logic        rst;
  logic        start12, start1;
  logic [31:0] ia12, ib12, ia1, ib1;
  logic [4:0]  addr12;
  logic [1:0]  addr1;
  logic [31:0] s12, s1;
  logic [31:0] oa12, ob12, oa1, ob1;
  logic        busy12, done12, busy1, done1;

  logic [31:0] mem12 [T12];
  logic [31:0] mem1  [4];

  int n_checks = 0;
  int n_fail   = 0;

  rc5_encrypt #(.W(32), .R(12)) dut (
    .clk(clk), .rst(rst), .iStart(start12), .iA(ia12), .iB(ib12),
    .oS_address(addr12), .iS_sub_i(s12), .oA(oa12), .oB(ob12),
    .oBusy(busy12), .oDone(done12)
  );

  rc5_encrypt #(.W(32), .R(1)) dut1 (
    .clk(clk), .rst(rst), .iStart(start1), .iA(ia1), .iB(ib1),
    .oS_address(addr1), .iS_sub_i(s1), .oA(oa1), .oB(ob1),
    .oBusy(busy1), .oDone(done1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    s12 <= mem12[addr12];
    s1  <= mem1[addr1];
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    int m;
    m = n % 32;
    if (m == 0) return x;
    return (x << m) | (x >> (32 - m));
  endfunction

  function automatic logic [63:0] model12(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    x = a + mem12[0];
    y = b + mem12[1];
    for (int i = 1; i <= 12; i++) begin
      x = rotl(x ^ y, int'(y % 32)) + mem12[2*i];
      y = rotl(y ^ x, int'(x % 32)) + mem12[2*i+1];
    end
    return {x, y};
  endfunction

  // RC5-32/12/16 key expansion for the all-zero 16-byte key.
  task automatic key_schedule_zero();
    logic [31:0] l [4];
    logic [31:0] ka, kb;
    int i, j;
    mem12[0] = 32'hB7E15163;
    for (int k = 1; k < T12; k++) mem12[k] = mem12[k-1] + 32'h9E3779B9;
    for (int k = 0; k < 4; k++) l[k] = '0;
    ka = '0; kb = '0; i = 0; j = 0;
    for (int k = 0; k < 3 * T12; k++) begin
      mem12[i] = rotl(mem12[i] + ka + kb, 3);
      ka = mem12[i];
      l[j] = rotl(l[j] + ka + kb, int'((ka + kb) % 32));
      kb = l[j];
      i = (i + 1) % T12;
      j = (j + 1) % 4;
    end
  endtask

  task automatic fill_random12();
    for (int k = 0; k < T12; k++) mem12[k] = $urandom;
  endtask

  // Runs one block on the R=12 core for a fixed window of 2T+4 samples
  // (sampled 1 time unit after each edge). With disturb set, iStart is pulsed
  // with junk data mid-run and in the DONE cycle.
  task automatic run12(input logic [31:0] a, input logic [31:0] b, input bit disturb,
                       output int lat, output int ndone, output logic [31:0] ra,
                       output logic [31:0] rb, output bit addr_ok, output bit busy_ok);
    int prev, nchg;
    lat = -1; ndone = 0; ra = 'x; rb = 'x; addr_ok = 1'b1; busy_ok = 1'b1;
    ia12 = a; ib12 = b; start12 = 1'b1;
    @(posedge clk); #1;
    start12 = 1'b0; ia12 = $urandom; ib12 = $urandom;
    if (addr12 !== 5'd0) addr_ok = 1'b0;
    if (busy12 !== 1'b1) busy_ok = 1'b0;
    prev = 0; nchg = 0;
    for (int cyc = 1; cyc <= 2 * T12 + 3; cyc++) begin
      @(posedge clk); #1;
      start12 = disturb && (cyc == 10 || cyc == 30 || cyc == 2 * T12);
      if (start12) begin ia12 = $urandom; ib12 = $urandom; end
      if (busy12 !== (cyc < 2 * T12)) busy_ok = 1'b0;
      if (done12 === 1'b1) begin
        ndone++;
        if (lat < 0) begin lat = cyc; ra = oa12; rb = ob12; end
      end
      if (int'(addr12) != prev) begin
        if (int'(addr12) != prev + 1 || cyc != 2 * int'(addr12)) addr_ok = 1'b0;
        prev = int'(addr12);
        nchg++;
      end
    end
    start12 = 1'b0;
    if (nchg != T12 - 1 || prev != T12 - 1) addr_ok = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start12 = 1'b0; start1 = 1'b0;
    ia12 = '0; ib12 = '0; ia1 = '0; ib1 = '0;
    repeat (2) @(posedge clk);
    for (int cyc = 0; cyc < 6; cyc++) begin
      #1;
      start12 = cyc[0]; start1 = cyc[0];
      ia12 = $urandom; ib12 = $urandom; ia1 = $urandom; ib1 = $urandom;
      @(posedge clk); #1;
      n_checks++;
      if ({oa12, ob12, busy12, done12, addr12} !== 71'd0) begin
        n_fail++;
        $display("FAIL reset_hold12 got %h required 0", {oa12, ob12, busy12, done12, addr12});
      end
      n_checks++;
      if ({oa1, ob1, busy1, done1, addr1} !== 68'd0) begin
        n_fail++;
        $display("FAIL reset_hold1 got %h required 0", {oa1, ob1, busy1, done1, addr1});
      end
      @(negedge clk);
    end
    start12 = 1'b0; start1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({oa12, ob12, busy12, done12, addr12, oa1, ob1, busy1, done1, addr1} !== 139'd0) begin
        n_fail++;
        $display("FAIL reset_release got %h/%h required 0",
                 {oa12, ob12, busy12, done12, addr12}, {oa1, ob1, busy1, done1, addr1});
      end
    end
  endtask

  task automatic test_zero();
    int lat, nd; logic [31:0] ra, rb; bit aok, bok;
    for (int k = 0; k < T12; k++) mem12[k] = '0;
    run12(32'd0, 32'd0, 1'b0, lat, nd, ra, rb, aok, bok);
    n_checks++;
    if (lat != 52 || nd != 1) begin
      n_fail++; $display("FAIL zero_latency got lat=%0d pulses=%0d required lat=52 pulses=1", lat, nd);
    end
    n_checks++;
    if (ra !== 32'd0 || rb !== 32'd0) begin
      n_fail++; $display("FAIL zero_data got %h %h required 0 0", ra, rb);
    end
    n_checks++;
    if (!aok) begin n_fail++; $display("FAIL zero_addr_seq got bad sequence required 0..25"); end
    n_checks++;
    if (!bok) begin n_fail++; $display("FAIL zero_busy got bad busy window required E0..E0+51"); end
  endtask

  task automatic test_hand();
    int lat; logic [31:0] ra, rb;
    mem1[0] = 32'd1; mem1[1] = '0; mem1[2] = '0; mem1[3] = '0;
    lat = -1; ra = 'x; rb = 'x;
    ia1 = '0; ib1 = '0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1 && lat < 0) begin lat = cyc; ra = oa1; rb = ob1; end
    end
    n_checks++;
    if (lat != 8) begin n_fail++; $display("FAIL hand_latency got %0d required 8", lat); end
    n_checks++;
    if (ra !== 32'd1 || rb !== 32'd2) begin
      n_fail++; $display("FAIL hand_vector got %h %h required 1 2", ra, rb);
    end
  endtask

  task automatic test_standard();
    int lat, nd; logic [31:0] ra, rb; bit aok, bok;
    key_schedule_zero();
    run12(32'd0, 32'd0, 1'b0, lat, nd, ra, rb, aok, bok);
    n_checks++;
    if (ra !== 32'hEEDBA521 || rb !== 32'h6D8F4B15) begin
      n_fail++; $display("FAIL standard_vector got %h %h required eedba521 6d8f4b15", ra, rb);
    end
    n_checks++;
    if (lat != 52) begin n_fail++; $display("FAIL standard_latency got %0d required 52", lat); end
  endtask

  task automatic test_random();
    int lat, nd; logic [31:0] ra, rb, a, b; logic [63:0] exp; bit aok, bok;
    for (int n = 0; n < 5; n++) begin
      fill_random12();
      a = $urandom; b = $urandom;
      exp = model12(a, b);
      run12(a, b, 1'b0, lat, nd, ra, rb, aok, bok);
      n_checks++;
      if ({ra, rb} !== exp || lat != 52 || nd != 1) begin
        n_fail++;
        $display("FAIL random_%0d got %h lat=%0d required %h lat=52", n, {ra, rb}, lat, exp);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat1, lat2, nd1, nd2; logic [31:0] ra1, rb1, ra2, rb2, a, b;
    bit ao1, bo1, ao2, bo2; logic [63:0] exp;
    fill_random12();
    a = $urandom; b = $urandom;
    exp = model12(a, b);
    run12(a, b, 1'b0, lat1, nd1, ra1, rb1, ao1, bo1);
    run12(a, b, 1'b1, lat2, nd2, ra2, rb2, ao2, bo2);
    n_checks++;
    if ({ra2, rb2} !== {ra1, rb1} || {ra2, rb2} !== exp) begin
      n_fail++; $display("FAIL busy_start_data got %h required %h", {ra2, rb2}, exp);
    end
    n_checks++;
    if (lat2 != 52 || nd2 != 1 || !ao2 || !bo2) begin
      n_fail++;
      $display("FAIL busy_start_timing got lat=%0d pulses=%0d addr_ok=%0d busy_ok=%0d required 52 1 1 1",
               lat2, nd2, ao2, bo2);
    end
    n_checks++;
    if (busy12 !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_done_cycle got busy=%b required 0", busy12);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nd, seen; logic [31:0] ra, rb, a, b; logic [63:0] exp; bit aok, bok;
    fill_random12();
    a = $urandom; b = $urandom;
    ia12 = a; ib12 = b; start12 = 1'b1;
    @(posedge clk); #1;
    start12 = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin @(posedge clk); #1; end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({oa12, ob12, busy12, done12, addr12} !== 71'd0) begin
      n_fail++; $display("FAIL reset_mid_async got %h required 0", {oa12, ob12, busy12, done12, addr12});
    end
    seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 2) rst = 1'b0;
      if (done12 !== 1'b0 || busy12 !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL reset_mid_no_done got %0d active cycles required 0", seen);
    end
    exp = model12(a, b);
    run12(a, b, 1'b0, lat, nd, ra, rb, aok, bok);
    n_checks++;
    if ({ra, rb} !== exp || lat != 52 || !aok) begin
      n_fail++;
      $display("FAIL reset_mid_restart got %h lat=%0d addr_ok=%0d required %h lat=52 1", {ra, rb}, lat, aok, exp);
    end
  endtask

  task automatic test_back_to_back();
    int second, lat2; bit low; logic [31:0] a, b, r1a, r1b, r2a, r2b; logic [63:0] exp;
    fill_random12();
    a = $urandom; b = $urandom;
    exp = model12(a, b);
    second = -1; low = 1'b0; r1a = 'x; r1b = 'x; r2a = 'x; r2b = 'x; lat2 = -1;
    ia12 = a; ib12 = b; start12 = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 2 * T12 + 10 && second < 0; cyc++) begin
      @(posedge clk); #1;
      if (done12 === 1'b1) begin r1a = oa12; r1b = ob12; end
      if (busy12 === 1'b0) low = 1'b1;
      else if (low) second = cyc;
    end
    start12 = 1'b0;
    n_checks++;
    if (second != 2 * T12 + 2) begin
      n_fail++; $display("FAIL b2b_accept got %0d required %0d", second, 2 * T12 + 2);
    end
    n_checks++;
    if ({r1a, r1b} !== exp) begin
      n_fail++; $display("FAIL b2b_first got %h required %h", {r1a, r1b}, exp);
    end
    for (int cyc = 1; cyc <= 2 * T12 + 4 && lat2 < 0; cyc++) begin
      @(posedge clk); #1;
      if (done12 === 1'b1) begin lat2 = cyc; r2a = oa12; r2b = ob12; end
    end
    n_checks++;
    if ({r2a, r2b} !== exp || lat2 != 2 * T12) begin
      n_fail++; $display("FAIL b2b_second got %h lat=%0d required %h lat=%0d", {r2a, r2b}, lat2, exp, 2 * T12);
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_hand();
    test_standard();
    test_random();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
